// File: rtl/alu_issue.sv
// alu_issue: operand-fetch / writeback stage wrapped around a registered ALU.
// Holds the architectural register file, accepts one register-register
// instruction at a time and sequences it IDLE -> EXEC -> WB.
// Optional build macro: ALU_ISSUE_BYPASS_EN (accept in WB, forward alu_out).
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_* are sampled only on that edge and may
// change freely afterwards. instr_ready depends on state only.
module alu_issue #(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_rs1,
  input  logic [REG_ADDR_W-1:0] instr_rs2,
  output logic [3:0]            alu_op,
  output logic [WORD_SIZE-1:0]  alu_in1,
  output logic [WORD_SIZE-1:0]  alu_in2,
  output logic                  alu_able,
  input  logic [WORD_SIZE-1:0]  alu_out,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [WORD_SIZE-1:0]  wb_data,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  localparam int NREGS = 2 ** REG_ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // r_state is the FSM state; bind checkers to it by hierarchical name.
  logic [1:0]            r_state;
  logic [WORD_SIZE-1:0]  r_regs [NREGS];
  logic [REG_ADDR_W-1:0] r_rd;

  logic                  w_accept;
  logic [WORD_SIZE-1:0]  w_opnd1;
  logic [WORD_SIZE-1:0]  w_opnd2;

  // Ready is a pure function of state.
`ifdef ALU_ISSUE_BYPASS_EN
  assign instr_ready = (r_state == S_IDLE) || (r_state == S_WB);
`else
  assign instr_ready = (r_state == S_IDLE);
`endif

  assign w_accept = instr_valid && instr_ready;

  // Register 0 is never written, so a plain array read already yields 0 there.
  assign dbg_data = r_regs[dbg_addr];

  // Operand selection; with bypass, the result retiring this edge is forwarded.
  always_comb begin
    w_opnd1 = r_regs[instr_rs1];
    w_opnd2 = r_regs[instr_rs2];
`ifdef ALU_ISSUE_BYPASS_EN
    if ((r_state == S_WB) && (instr_rs1 == r_rd) && (instr_rs1 != '0)) begin
      w_opnd1 = alu_out;
    end
    if ((r_state == S_WB) && (instr_rs2 == r_rd) && (instr_rs2 != '0)) begin
      w_opnd2 = alu_out;
    end
`endif
  end

  // FSM, register file, ALU drive and writeback reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_regs   <= '{default: '0};
      r_rd     <= '0;
      alu_op   <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_able <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            alu_op   <= instr_op;
            alu_in1  <= w_opnd1;
            alu_in2  <= w_opnd2;
            r_rd     <= instr_rd;
            alu_able <= 1'b1;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          // The ALU captures its operands on this closing edge.
          alu_able <= 1'b0;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (r_rd != '0) begin
            r_regs[r_rd] <= alu_out;
          end
          wb_valid <= 1'b1;
          wb_addr  <= r_rd;
          wb_data  <= alu_out;
          r_state  <= S_IDLE;
`ifdef ALU_ISSUE_BYPASS_EN
          if (w_accept) begin
            alu_op   <= instr_op;
            alu_in1  <= w_opnd1;
            alu_in2  <= w_opnd2;
            r_rd     <= instr_rd;
            alu_able <= 1'b1;
            r_state  <= S_EXEC;
          end
`endif
        end
        default: begin
          alu_able <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed bench for alu_issue with a registered-ALU stub,
// a timeline-level reference model and a per-cycle compare process.
module tb_alu_issue;

  localparam int W  = 32;
  localparam int AW = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_UND = 4'hF;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0;
  logic [AW-1:0] instr_rs1 = '0;
  logic [AW-1:0] instr_rs2 = '0;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_in1;
  logic [W-1:0]  alu_in2;
  logic          alu_able;
  logic [W-1:0]  alu_out = '0;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] dbg_addr = '0;
  logic [W-1:0]  dbg_data;

  alu_issue #(.WORD_SIZE(W), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_able(alu_able), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [W-1:0] last);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return last;
    endcase
  endfunction

  // ---------------- registered ALU stub ----------------
  logic [W-1:0] stub_seed_q[$];
  always @(posedge clk) begin
    if (alu_able) begin
      if (stub_seed_q.size() > 0) alu_out <= stub_seed_q.pop_front();
      else alu_out <= alu_f(alu_op, alu_in1, alu_in2, alu_out);
    end
  end

  // ---------------- reference model ----------------
  // An accepted instruction computes its result from the architectural
  // registers as they stand after anything retiring on the same edge,
  // then retires two edges later.
  logic [W-1:0]      m_regs [16];
  logic [W-1:0]      m_seed_q[$];
  logic [AW+W-1:0]   exp_q[$];
  logic              m_ready = 1'b1, m_able = 1'b0, m_wbv = 1'b0, m_pend = 1'b0;
  int                m_cnt = 0, m_acc_cnt = 0;
  logic [3:0]        m_op = '0;
  logic [W-1:0]      m_in1 = '0, m_in2 = '0, m_val = '0, m_last = '0;
  logic [AW-1:0]     m_rd = '0;

  initial for (int i = 0; i < 16; i++) m_regs[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_pend = 1'b0; m_cnt = 0; m_ready = 1'b1; m_able = 1'b0; m_wbv = 1'b0;
      exp_q.delete();
    end else begin
      logic acc;
      acc   = instr_valid && m_ready;
      m_wbv = 1'b0;
      if (m_pend && m_cnt == 1) begin
        if (m_rd != 0) m_regs[m_rd] = m_val;
        m_wbv = 1'b1;
        exp_q.push_back({m_rd, m_val});
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_cnt  = 1;
        m_last = m_val;
      end
      m_able = 1'b0;
      if (acc) begin
        m_op  = instr_op;
        m_in1 = m_regs[instr_rs1];
        m_in2 = m_regs[instr_rs2];
        if (m_seed_q.size() > 0) m_val = m_seed_q.pop_front();
        else m_val = alu_f(instr_op, m_in1, m_in2, m_last);
        m_rd   = instr_rd;
        m_pend = 1'b1;
        m_cnt  = 2;
        m_able = 1'b1;
        m_acc_cnt++;
      end
      m_ready = !m_pend || (BYP && m_cnt == 1);
    end
  end

  // ---------------- scoreboard / per-cycle compare ----------------
  int able_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("instr_ready", instr_ready, m_ready);
      chk("alu_able", alu_able, m_able);
      if (alu_able) able_cnt++;
      if (m_able) begin
        chk("alu_op", alu_op, m_op);
        chk("alu_in1", alu_in1, m_in1);
        chk("alu_in2", alu_in2, m_in2);
      end
      chk("wb_valid", wb_valid, m_wbv);
      if (wb_valid) begin
        chk("wb_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          logic [AW+W-1:0] e;
          e = exp_q.pop_front();
          chk("wb_addr", wb_addr, e[AW+W-1:W]);
          chk("wb_data", wb_data, e[W-1:0]);
        end
      end
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit acc;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk); #1;
        acc = 1'b1;
      end
    end
    instr_valid = 1'b0;
    chk("issue_accepted", acc, 1);
  endtask

  task automatic seed(input logic [W-1:0] v);
    stub_seed_q.push_back(v);
    m_seed_q.push_back(v);
  endtask

  // Counts negedges from the EXEC cycle until the writeback pulse.
  task automatic wait_wb(output int idx, output int ables,
                         output logic [AW-1:0] a, output logic [W-1:0] d);
    bit got;
    got = 1'b0; idx = 0; ables = 0; a = '0; d = '0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (alu_able) ables++;
      if (wb_valid) begin
        got = 1'b1; idx = i; a = wb_addr; d = wb_data;
      end
    end
    chk("wb_seen", got, 1);
  endtask

  task automatic check_reg(input logic [AW-1:0] a, input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    chk($sformatf("reg%0d", a), dbg_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int idx, ables, c0, m0, wbn;
    logic [AW-1:0] a;
    logic [W-1:0]  d;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_able", alu_able, 0);
    chk("rst_wb_valid", wb_valid, 0);
    for (int i = 0; i < 16; i++) check_reg(i[AW-1:0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Preload r1=5, r2=7 through the seeded ALU, back to back.
    seed(32'd5); issue(ALU_ADD, 4'd1, 4'd0, 4'd0);
    seed(32'd7); issue(ALU_ADD, 4'd2, 4'd0, 4'd0);
    idle(4);
    check_reg(4'd1, 32'd5);
    check_reg(4'd2, 32'd7);

    // r3 = r1 + r2 = 12, three edges from accept to visible result.
    issue(ALU_ADD, 4'd3, 4'd1, 4'd2);
    wait_wb(idx, ables, a, d);
    chk("add_latency", idx, 3);
    chk("add_able_cycles", ables, 1);
    chk("add_wb_addr", a, 3);
    chk("add_wb_data", d, 12);
    check_reg(4'd3, 32'd12);
    idle(3);

    // r0 = r2 - r1 = 2 is reported but discarded.
    issue(ALU_SUB, 4'd0, 4'd2, 4'd1);
    wait_wb(idx, ables, a, d);
    chk("sub_wb_addr", a, 0);
    chk("sub_wb_data", d, 2);
    check_reg(4'd0, 32'd0);
    idle(3);

    // Undefined opcode writes back the stale ALU value (2).
    issue(ALU_UND, 4'd8, 4'd1, 4'd2);
    wait_wb(idx, ables, a, d);
    chk("und_wb_data", d, 2);
    check_reg(4'd8, 32'd2);
    idle(3);

    // r9 = r3 & r2 = 12 & 7 = 4.
    issue(ALU_AND, 4'd9, 4'd3, 4'd2);
    idle(4);
    check_reg(4'd9, 32'd4);

    // Dependent pair: r4 = r1 + r2 = 12, then r5 = r4 + r4 = 24.
    issue(ALU_ADD, 4'd4, 4'd1, 4'd2);
    issue(ALU_ADD, 4'd5, 4'd4, 4'd4);
    idle(5);
    check_reg(4'd4, 32'd12);
    check_reg(4'd5, 32'd24);

    // instr_valid held for 9 edges.
    c0 = able_cnt; m0 = m_acc_cnt;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_op = ALU_ADD; instr_rd = 4'd7; instr_rs1 = 4'd1; instr_rs2 = 4'd2;
    repeat (9) @(posedge clk);
    #1;
    instr_valid = 1'b0;
    idle(4);
`ifdef ALU_ISSUE_BYPASS_EN
    chk("hold9_accepts", able_cnt - c0, m_acc_cnt - m0);
`else
    chk("hold9_accepts", able_cnt - c0, 3);
`endif
    check_reg(4'd7, 32'd12);

    // Reset during EXEC abandons the instruction.
    issue(ALU_ADD, 4'd6, 4'd1, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_able", alu_able, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_ready", instr_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wbn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wb_valid) wbn++;
    end
    chk("mid_rst_no_wb", wbn, 0);
    chk("mid_rst_idle_able", alu_able, 0);
    check_reg(4'd6, 32'd0);
    check_reg(4'd1, 32'd0);

    // Post-reset sanity: r10 = r0 + r0 via seed 9.
    seed(32'd9); issue(ALU_ADD, 4'd10, 4'd0, 4'd0);
    idle(4);
    check_reg(4'd10, 32'd9);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
